// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out shifter. A word offered with i_valid while the
//   block is idle is captured and emitted one bit per clock, LSB-first or
//   MSB-first, starting the cycle after the load edge. Frames are always
//   separated by at least one idle cycle.
//
//   Optional feature macro: PISO_SERIALIZER_PARITY_EN
//     When defined, an even-parity bit (XOR of the captured word) follows
//     the data bits and carries o_last. Frame length becomes BITS+1.
//
// Parameters
//   BITS           data word width (>= 2)
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_valid        parallel word offered for loading
//   o_ready        block can accept a word this cycle (combinational)
//   i_data         parallel word, sampled only on load
//   i_right_nleft  1 = LSB first, 0 = MSB first, sampled only on load
//   o_bit_out      serial data bit (registered)
//   o_bit_valid    o_bit_out carries a frame bit (registered)
//   o_last         current bit is the final bit of the frame (registered)
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [BITS-1:0] i_data,
  input  logic            i_right_nleft,
  output logic            o_bit_out,
  output logic            o_bit_valid,
  output logic            o_last
);

  localparam int CW = $clog2(BITS + 1);
  // Counter holds the index of the bit currently on o_bit_out.
  localparam logic [CW-1:0] LAST_IDX = CW'(BITS - 1);
`ifndef PISO_SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] PEN_IDX  = CW'(BITS - 2);
`endif

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
  } state_t;
`endif

  state_t          r_state;
  logic [BITS-1:0] r_shift;    // bits still waiting to be emitted
  logic [CW-1:0]   r_cnt;
  logic            r_dir;      // captured i_right_nleft
  logic            r_bit_out;
  logic            r_bit_valid;
  logic            r_last;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic            r_par;      // even parity of the captured word
`endif

  // Ready is combinational so a reset cycle can never accept a load.
  assign o_ready     = (r_state == ST_IDLE) && !i_rst;
  assign o_bit_out   = r_bit_out;
  assign o_bit_valid = r_bit_valid;
  assign o_last      = r_last;

  // FSM, shift register, counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_last      <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_out   <= 1'b0;
          r_bit_valid <= 1'b0;
          r_last      <= 1'b0;
          if (i_valid) begin
            // The first bit is registered straight from i_data so it
            // appears in the cycle after the load edge; the shift register
            // keeps only the remaining bits.
            r_state     <= ST_SHIFT;
            r_cnt       <= '0;
            r_dir       <= i_right_nleft;
            r_bit_valid <= 1'b1;
            if (i_right_nleft) begin
              r_bit_out <= i_data[0];
              r_shift   <= {1'b0, i_data[BITS-1:1]};
            end else begin
              r_bit_out <= i_data[BITS-1];
              r_shift   <= {i_data[BITS-2:0], 1'b0};
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            r_par       <= ^i_data;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (r_cnt == LAST_IDX) begin
            r_shift <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            r_state     <= ST_PARITY;
            r_bit_out   <= r_par;
            r_bit_valid <= 1'b1;
            r_last      <= 1'b1;
`else
            r_state     <= ST_IDLE;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_last      <= 1'b0;
`endif
          end else begin
            r_state     <= ST_SHIFT;
            r_cnt       <= r_cnt + CW'(1);
            r_bit_valid <= 1'b1;
            if (r_dir) begin
              r_bit_out <= r_shift[0];
              r_shift   <= {1'b0, r_shift[BITS-1:1]};
            end else begin
              r_bit_out <= r_shift[BITS-1];
              r_shift   <= {r_shift[BITS-2:0], 1'b0};
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            r_last <= 1'b0;
`else
            // Next bit is the BITS-th data bit.
            r_last <= (r_cnt == PEN_IDX);
`endif
          end
        end

`ifdef PISO_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          r_state     <= ST_IDLE;
          r_bit_out   <= 1'b0;
          r_bit_valid <= 1'b0;
          r_last      <= 1'b0;
        end
`endif

        default: begin
          r_state     <= ST_IDLE;
          r_shift     <= '0;
          r_cnt       <= '0;
          r_bit_out   <= 1'b0;
          r_bit_valid <= 1'b0;
          r_last      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer (BITS = 8). Each load pushes the
//   expected bit stream to a queue; every clock the outputs are compared
//   against the head of the queue, or against idle values when it is empty.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_serializer;

  localparam int BITS = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FLEN = BITS + 1;
`else
  localparam int FLEN = BITS;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            ready;
  logic [BITS-1:0] data;
  logic            rnl;
  logic            bit_out;
  logic            bit_valid;
  logic            last;

  piso_serializer #(.BITS(BITS)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_data        (data),
    .i_right_nleft (rnl),
    .o_bit_out     (bit_out),
    .o_bit_valid   (bit_valid),
    .o_last        (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic l;
  } exp_t;

  exp_t            q[$];
  int              tests = 0;
  int              fails = 0;
  logic [BITS-1:0] rx_r;   // right-shifting receiver
  logic [BITS-1:0] rx_l;   // left-shifting receiver
  int              rx_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare all outputs against the scoreboard.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".valid"}, {31'd0, bit_valid}, 32'd1);
      chk({tag, ".bit"},   {31'd0, bit_out},   {31'd0, e.b});
      chk({tag, ".last"},  {31'd0, last},      {31'd0, e.l});
      chk({tag, ".ready"}, {31'd0, ready},     32'd0);
    end else begin
      chk({tag, ".idle_valid"}, {31'd0, bit_valid}, 32'd0);
      chk({tag, ".idle_bit"},   {31'd0, bit_out},   32'd0);
      chk({tag, ".idle_last"},  {31'd0, last},      32'd0);
      chk({tag, ".idle_ready"}, {31'd0, ready},     {31'd0, ~rst});
    end
    if (bit_valid === 1'b1 && rx_n < BITS) begin
      rx_r = {bit_out, rx_r[BITS-1:1]};
      rx_l = {rx_l[BITS-2:0], bit_out};
      rx_n++;
    end
  endtask

  task automatic push_frame(input logic [BITS-1:0] d, input logic lsb);
    exp_t e;
    for (int i = 0; i < BITS; i++) begin
      e.b = lsb ? d[i] : d[BITS-1-i];
`ifdef PISO_SERIALIZER_PARITY_EN
      e.l = 1'b0;
`else
      e.l = (i == BITS - 1);
`endif
      q.push_back(e);
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    e.b = ^d;
    e.l = 1'b1;
    q.push_back(e);
`endif
  endtask

  // Load a word; afterwards scramble the inputs to show they are ignored.
  task automatic load(input string tag, input logic [BITS-1:0] d, input logic lsb);
    chk({tag, ".ready_before"}, {31'd0, ready}, 32'd1);
    rx_r  = '0;
    rx_l  = '0;
    rx_n  = 0;
    valid = 1'b1;
    data  = d;
    rnl   = lsb;
    push_frame(d, lsb);
    step({tag, ".b1"});
    valid = 1'b0;
    data  = ~d;
    rnl   = ~lsb;
  endtask

  task automatic frame(input string tag, input logic [BITS-1:0] d, input logic lsb);
    load(tag, d, lsb);
    repeat (FLEN - 1) step(tag);
    step({tag, ".after"});
    if (lsb) chk({tag, ".rx_right"}, {24'd0, rx_r}, {24'd0, d});
    else     chk({tag, ".rx_left"},  {24'd0, rx_l}, {24'd0, d});
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    rnl   = 1'b0;
    rx_r  = '0;
    rx_l  = '0;
    rx_n  = 0;

    // Reset state
    step("reset0");
    step("reset1");
    chk("reset.ready_in_rst", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset.ready_released", {31'd0, ready}, 32'd1);
    step("post_reset");

    // 0xA5 MSB-first, then 0x01 LSB-first
    frame("a5_msb", 8'hA5, 1'b0);
    frame("01_lsb", 8'h01, 1'b1);

    // Offer 0xFF mid-frame: must be ignored
    load("3c", 8'h3C, 1'b0);
    step("3c");
    valid = 1'b1;
    data  = 8'hFF;
    step("3c.ignored_offer");
    valid = 1'b0;
    repeat (FLEN - 3) step("3c");
    step("3c.after");
    chk("3c.rx_left", {24'd0, rx_l}, 32'h3C);

    // Reset during bit 4 aborts the frame
    load("ff_abort", 8'hFF, 1'b1);
    repeat (3) step("ff_abort");
    rst = 1'b1;
    q.delete();
    step("ff_abort.rst");
    rst = 1'b0;
    step("ff_abort.released");
    frame("81_msb", 8'h81, 1'b0);

    // Reset wins over a simultaneous load
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    step("rst_vs_load");
    rst   = 1'b0;
    valid = 1'b0;
    step("rst_vs_load.after");
    step("rst_vs_load.after2");

`ifdef PISO_SERIALIZER_PARITY_EN
    frame("par07", 8'h07, 1'b1);
    frame("par03", 8'h03, 1'b1);
`endif

    // A few random frames, both directions
    for (int k = 0; k < 4; k++) begin
      frame("rand", BITS'($urandom_range(0, 255)), k[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
